// File: rtl/ioctl_rom_arbiter_pkg.sv
// Shared types for the ROM download / read arbiter.
// Holds the FSM state encoding, the download target index of the ROM, and requester ids.
// No logic; imported by every file of the block.
package ioctl_rom_arbiter_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_e;

    typedef enum logic {
        CPU = 1'b0,
        GFX = 1'b1
    } req_id_e;

    // ioctl_index value that targets the game ROM
    localparam logic [7:0] ROM_INDEX = 8'd0;

    // Round-robin successor: after serving one requester, favour the other
    function automatic req_id_e other_req(input req_id_e id);
        return (id == CPU) ? GFX : CPU;
    endfunction

endpackage

// File: rtl/ioctl_rom_arbiter_if.sv
// Bundle of download, requester and ROM-port signals for ioctl_rom_arbiter.
// master = surrounding system (download source, requesters, RAM); slave = the arbiter.
// checksum exists only when ROM_CHECKSUM_EN is defined.
interface ioctl_rom_arbiter_if #(
    parameter int AW = 16
);
    logic          user_reset;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;

    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ack;
    logic [7:0]    cpu_data;

    logic          gfx_req;
    logic [AW-1:0] gfx_addr;
    logic          gfx_ack;
    logic [7:0]    gfx_data;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;

    logic          core_reset;
    logic          rom_loaded;
`ifdef ROM_CHECKSUM_EN
    logic [7:0]    checksum;
`endif

    modport master (
        output user_reset, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output cpu_req, cpu_addr, gfx_req, gfx_addr, mem_dout,
        input  cpu_ack, cpu_data, gfx_ack, gfx_data,
        input  mem_addr, mem_we, mem_din, core_reset, rom_loaded
`ifdef ROM_CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  user_reset, ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  cpu_req, cpu_addr, gfx_req, gfx_addr, mem_dout,
        output cpu_ack, cpu_data, gfx_ack, gfx_data,
        output mem_addr, mem_we, mem_din, core_reset, rom_loaded
`ifdef ROM_CHECKSUM_EN
        , output checksum
`endif
    );

endinterface

// File: rtl/ioctl_rom_arbiter_reset_stretch.sv
// Hold counter that keeps the core in reset for RST_HOLD cycles.
// load restarts the count; count decrements by one per cycle down to zero.
// done flags the cycle in which the count reaches zero (count is at 1 or already 0).
module reset_stretch #(
    parameter int RST_HOLD = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic count_i,
    output logic done_o
);
    // one spare code so RST_HOLD = 0 still yields a legal width
    localparam int CW = $clog2(RST_HOLD + 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // next count: reload wins over decrement, saturate at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(RST_HOLD);
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // count register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // independent of count_i so the FSM can use it without a combinational loop
    assign done_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/ioctl_rom_arbiter.sv
// Loads the game ROM from ioctl downloads, then shares its read port between CPU and video round-robin.
// Latency: download bytes reach the ROM port combinationally; a granted read is acked the next cycle.
// Backpressure: requesters hold req until ack; one read in flight, so one read per two cycles. Option: ROM_CHECKSUM_EN.
module ioctl_rom_arbiter
    import ioctl_rom_arbiter_pkg::*;
#(
    parameter int AW       = 16,
    parameter int RST_HOLD = 16
) (
    input  logic               clk_sys,
    input  logic               reset,
    ioctl_rom_arbiter_if.slave bus
);

    state_e        state_q, state_d;
    logic          rom_loaded_q;
    req_id_e       ptr_q;
    req_id_e       gnt_id;
    logic          cpu_ack_q, gfx_ack_q;
    logic [7:0]    cpu_data_q, gfx_data_q;
    logic [7:0]    cpu_data_d, gfx_data_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    logic          addr_fits;
    logic          wr_accept;
    logic          busy;
    logic          grant;
    logic          hold_load, hold_count, hold_done, loaded_set;

    // bytes beyond the ROM window are dropped, not wrapped
    assign addr_fits = ((32'(bus.ioctl_addr) >> AW) == 32'd0);
    assign wr_accept = !reset && (state_q == LOAD) && bus.ioctl_wr &&
                       (bus.ioctl_index == ROM_INDEX) && addr_fits;

    // the cycle after a grant carries the ack, so it never grants
    assign busy  = cpu_ack_q || gfx_ack_q;
    assign grant = !reset && (state_q == RUN) && !busy && (bus.cpu_req || bus.gfx_req);

    // requester choice: a lone requester wins, contention goes to the pointer
    always_comb begin
        gnt_id = ptr_q;
        if (bus.cpu_req && !bus.gfx_req) begin
            gnt_id = CPU;
        end else if (bus.gfx_req && !bus.cpu_req) begin
            gnt_id = GFX;
        end
    end

    // ROM port address: download write, read grant, otherwise hold the last address
    always_comb begin
        mem_addr_d = mem_addr_q;
        if (wr_accept) begin
            mem_addr_d = bus.ioctl_addr[AW-1:0];
        end else if (grant) begin
            mem_addr_d = (gnt_id == CPU) ? bus.cpu_addr : bus.gfx_addr;
        end
    end

    // FSM next state and hold-counter control
    always_comb begin
        state_d    = state_q;
        hold_load  = 1'b0;
        hold_count = 1'b0;
        loaded_set = 1'b0;
        case (state_q)
            BOOT: begin
                if (bus.ioctl_download) state_d = LOAD;
            end
            LOAD: begin
                if (!bus.ioctl_download) begin
                    state_d    = HOLD;
                    hold_load  = 1'b1;
                    loaded_set = 1'b1;
                end
            end
            HOLD: begin
                if (bus.ioctl_download) begin
                    state_d = LOAD;
                end else if (bus.user_reset) begin
                    hold_load = 1'b1;
                end else begin
                    hold_count = 1'b1;
                    if (hold_done) state_d = RUN;
                end
            end
            RUN: begin
                if (bus.ioctl_download) begin
                    state_d = LOAD;
                end else if (bus.user_reset) begin
                    state_d   = HOLD;
                    hold_load = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    reset_stretch #(
        .RST_HOLD (RST_HOLD)
    ) u_reset_stretch (
        .clk_i   (clk_sys),
        .reset_i (reset),
        .load_i  (hold_load),
        .count_i (hold_count),
        .done_o  (hold_done)
    );

    // RAM output is valid in the ack cycle; the register keeps it until the next ack
    assign cpu_data_d = cpu_ack_q ? bus.mem_dout : cpu_data_q;
    assign gfx_data_d = gfx_ack_q ? bus.mem_dout : gfx_data_q;

    // state, sticky loaded flag, ack/data, pointer and address hold
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= BOOT;
            rom_loaded_q <= 1'b0;
            ptr_q        <= CPU;
            cpu_ack_q    <= 1'b0;
            gfx_ack_q    <= 1'b0;
            cpu_data_q   <= '0;
            gfx_data_q   <= '0;
            mem_addr_q   <= '0;
        end else begin
            state_q    <= state_d;
            if (loaded_set) rom_loaded_q <= 1'b1;
            // a download starting in the grant cycle aborts the read: no ack
            cpu_ack_q  <= grant && (gnt_id == CPU) && (state_d != LOAD);
            gfx_ack_q  <= grant && (gnt_id == GFX) && (state_d != LOAD);
            cpu_data_q <= cpu_data_d;
            gfx_data_q <= gfx_data_d;
            mem_addr_q <= mem_addr_d;
            if (grant) ptr_q <= other_req(gnt_id);
        end
    end

    assign bus.mem_addr   = mem_addr_d;
    assign bus.mem_we     = wr_accept;
    assign bus.mem_din    = bus.ioctl_dout;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.gfx_ack    = gfx_ack_q;
    assign bus.cpu_data   = cpu_data_d;
    assign bus.gfx_data   = gfx_data_d;
    assign bus.rom_loaded = rom_loaded_q;
    // download or user reset request pulls the core into reset in the same cycle
    assign bus.core_reset = (state_q != RUN) || bus.ioctl_download || bus.user_reset;

`ifdef ROM_CHECKSUM_EN
    logic       dl_q;
    logic [7:0] checksum_q;

    // checksum restarts on each new download and sums only bytes written to the ROM
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q       <= 1'b0;
            checksum_q <= '0;
        end else begin
            dl_q <= bus.ioctl_download;
            if (bus.ioctl_download && !dl_q) begin
                checksum_q <= '0;
            end else if (wr_accept) begin
                checksum_q <= checksum_q + bus.ioctl_dout;
            end
        end
    end

    assign bus.checksum = checksum_q;
`else
    // no checksum port or logic in this build
`endif

endmodule

// File: tb/tb_ioctl_rom_arbiter.sv
// Self-checking bench for ioctl_rom_arbiter: downloads, filtering, round-robin reads, abort, resets.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A transaction-level model (reference ROM image, read queue, round-robin pointer) predicts outputs.
module tb_ioctl_rom_arbiter;

    localparam int AW       = 16;
    localparam int RST_HOLD = 16;

    logic clk_sys = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    ioctl_rom_arbiter_if #(.AW(AW)) bus ();

    ioctl_rom_arbiter #(
        .AW       (AW),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // synchronous ROM: data appears one cycle after the address
    logic [7:0] ram [0:(1<<AW)-1];
    always @(posedge clk_sys) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= ram[bus.mem_addr];
    end

    // reference model state
    logic [7:0]    ref_mem [0:63];
    logic [7:0]    exp_sum;
    logic [AW-1:0] m_last_addr;
    logic [7:0]    m_cpu_data, m_gfx_data;
    bit            m_rr;          // 0: CPU favoured, 1: GFX favoured
    bit            m_inflight;
    bit            m_id;
    logic [AW-1:0] m_addr;
    bit            req_c, req_g;
    logic [AW-1:0] a_c, a_g;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_inputs();
        bus.user_reset     = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = 8'd0;
        bus.cpu_req        = 1'b0;
        bus.cpu_addr       = '0;
        bus.gfx_req        = 1'b0;
        bus.gfx_addr       = '0;
    endtask

    // one byte strobe followed by a quiet cycle; state must already be LOAD
    task automatic send_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] dat);
        bit acc;
        acc = (idx == 8'd0) && ((32'(addr) >> AW) == 32'd0);
        bus.ioctl_wr    = 1'b1;
        bus.ioctl_index = idx;
        bus.ioctl_addr  = addr;
        bus.ioctl_dout  = dat;
        @(negedge clk_sys);
        check_eq("byte_we", 32'(bus.mem_we), 32'(acc));
        if (acc) begin
            check_eq("byte_addr", 32'(bus.mem_addr), 32'(addr[AW-1:0]));
            check_eq("byte_din", 32'(bus.mem_din), 32'(dat));
            exp_sum     = exp_sum + dat;
            m_last_addr = addr[AW-1:0];
            if (addr < 25'd64) ref_mem[addr[5:0]] = dat;
        end
        next_cycle();
        bus.ioctl_wr = 1'b0;
        @(negedge clk_sys);
        check_eq("gap_we", 32'(bus.mem_we), 32'd0);
        next_cycle();
    endtask

    task automatic start_download();
        bus.ioctl_download = 1'b1;
        exp_sum = 8'd0;
        @(negedge clk_sys);
        check_eq("dl_core_reset", 32'(bus.core_reset), 32'd1);
        next_cycle();
    endtask

    // drop download, then measure core_reset from the first cycle rom_loaded is seen
    task automatic finish_download();
        int k;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        check_eq("fall_core_reset", 32'(bus.core_reset), 32'd1);
        next_cycle();
        @(negedge clk_sys);
        check_eq("rom_loaded", 32'(bus.rom_loaded), 32'd1);
        k = 0;
        while (bus.core_reset && k < 200) begin
            k++;
            next_cycle();
            @(negedge clk_sys);
        end
        check_eq("hold_len", 32'(k), 32'(RST_HOLD));
`ifdef ROM_CHECKSUM_EN
        check_eq("checksum", 32'(bus.checksum), 32'(exp_sum));
`endif
        next_cycle();
    endtask

    // read traffic in RUN; force_both keeps both requesters asking continuously
    task automatic read_phase(input int ncyc, input bit force_both);
        for (int c = 0; c < ncyc + 12; c++) begin
            bit ack_c, ack_g, may;
            bit gid;
            logic [AW-1:0] gaddr;
            ack_c = m_inflight && (m_id == 1'b0);
            ack_g = m_inflight && (m_id == 1'b1);
            may   = (c < ncyc);
            if (ack_c) begin
                req_c = may && force_both;
                if (req_c) a_c = AW'($urandom_range(0, 63));
            end else if (!req_c && may && (force_both || ($urandom_range(0, 1) == 1))) begin
                req_c = 1'b1;
                a_c   = AW'($urandom_range(0, 63));
            end
            if (ack_g) begin
                req_g = may && force_both;
                if (req_g) a_g = AW'($urandom_range(0, 63));
            end else if (!req_g && may && (force_both || ($urandom_range(0, 1) == 1))) begin
                req_g = 1'b1;
                a_g   = AW'($urandom_range(0, 63));
            end
            bus.cpu_req  = req_c;
            bus.cpu_addr = a_c;
            bus.gfx_req  = req_g;
            bus.gfx_addr = a_g;
            @(negedge clk_sys);
            check_eq("cpu_ack", 32'(bus.cpu_ack), 32'(ack_c));
            check_eq("gfx_ack", 32'(bus.gfx_ack), 32'(ack_g));
            if (ack_c) m_cpu_data = ref_mem[m_addr[5:0]];
            if (ack_g) m_gfx_data = ref_mem[m_addr[5:0]];
            check_eq("cpu_data", 32'(bus.cpu_data), 32'(m_cpu_data));
            check_eq("gfx_data", 32'(bus.gfx_data), 32'(m_gfx_data));
            check_eq("rd_we", 32'(bus.mem_we), 32'd0);
            check_eq("run_core_reset", 32'(bus.core_reset), 32'd0);
            if (!m_inflight && (req_c || req_g)) begin
                gid   = (req_c && req_g) ? m_rr : !req_c;
                gaddr = gid ? a_g : a_c;
                check_eq("grant_addr", 32'(bus.mem_addr), 32'(gaddr));
                m_rr        = !gid;
                m_inflight  = 1'b1;
                m_id        = gid;
                m_addr      = gaddr;
                m_last_addr = gaddr;
            end else begin
                check_eq("hold_addr", 32'(bus.mem_addr), 32'(m_last_addr));
                m_inflight = 1'b0;
            end
            next_cycle();
            if (c >= ncyc && !m_inflight && !req_c && !req_g) break;
        end
        req_c = 1'b0;
        req_g = 1'b0;
        bus.cpu_req = 1'b0;
        bus.gfx_req = 1'b0;
    endtask

    initial begin
        int k;
        int r;
        idle_inputs();
        reset       = 1'b1;
        exp_sum     = 8'd0;
        m_last_addr = '0;
        m_cpu_data  = 8'd0;
        m_gfx_data  = 8'd0;
        m_rr        = 1'b0;
        m_inflight  = 1'b0;
        m_id        = 1'b0;
        m_addr      = '0;
        req_c       = 1'b0;
        req_g       = 1'b0;
        a_c         = '0;
        a_g         = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'd0;

        // reset values
        next_cycle();
        next_cycle();
        @(negedge clk_sys);
        check_eq("rst_core_reset", 32'(bus.core_reset), 32'd1);
        check_eq("rst_rom_loaded", 32'(bus.rom_loaded), 32'd0);
        check_eq("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check_eq("rst_gfx_ack", 32'(bus.gfx_ack), 32'd0);
        check_eq("rst_cpu_data", 32'(bus.cpu_data), 32'd0);
        check_eq("rst_gfx_data", 32'(bus.gfx_data), 32'd0);
        check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
`ifdef ROM_CHECKSUM_EN
        check_eq("rst_checksum", 32'(bus.checksum), 32'd0);
`endif
        next_cycle();
        reset = 1'b0;

        // power-up download of four bytes
        start_download();
        for (int i = 0; i < 4; i++) send_byte(8'd0, 25'(i), 8'(i + 1));
        finish_download();

        // full ROM window load mixed with bytes that must be filtered
        start_download();
        send_byte(8'd1, 25'd0, 8'hAA);
        send_byte(8'd0, 25'h10000, 8'h55);
        for (int a = 0; a < 64; a++) begin
            send_byte(8'd0, 25'(a), 8'($urandom));
            r = $urandom_range(0, 3);
            if (r == 0) send_byte(8'd1, 25'($urandom_range(0, 63)), 8'($urandom));
            else if (r == 1) send_byte(8'd0, 25'(32'h10000 + $urandom_range(0, 32'h00FF_FFFF)), 8'($urandom));
        end
        finish_download();

        // both requesters continuously: strict alternation starting with CPU
        read_phase(24, 1'b1);
        // random requests with deassert-on-ack
        read_phase(200, 1'b0);

        // user reset pulse of three cycles
        bus.user_reset = 1'b1;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            if (bus.core_reset) k++;
            next_cycle();
        end
        bus.user_reset = 1'b0;
        @(negedge clk_sys);
        while (bus.core_reset && k < 200) begin
            k++;
            next_cycle();
            @(negedge clk_sys);
        end
        check_eq("ureset_len", 32'(k), 32'(3 + RST_HOLD));
        check_eq("ureset_loaded", 32'(bus.rom_loaded), 32'd1);
        next_cycle();

        // download rising in the grant cycle of a CPU read aborts it
        bus.cpu_req        = 1'b1;
        bus.cpu_addr       = AW'(5);
        bus.ioctl_download = 1'b1;
        exp_sum            = 8'd0;
        @(negedge clk_sys);
        check_eq("abort_core_reset", 32'(bus.core_reset), 32'd1);
        check_eq("abort_we", 32'(bus.mem_we), 32'd0);
        next_cycle();
        bus.cpu_req = 1'b0;
        @(negedge clk_sys);
        check_eq("abort_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check_eq("abort_cpu_data", 32'(bus.cpu_data), 32'(m_cpu_data));
        next_cycle();
        send_byte(8'd0, 25'd12, 8'($urandom));
        send_byte(8'd0, 25'd40, 8'($urandom));
        finish_download();

        // reset in the middle of a download
        start_download();
        send_byte(8'd0, 25'd7, 8'($urandom));
        reset           = 1'b1;
        bus.ioctl_wr    = 1'b1;
        bus.ioctl_index = 8'd0;
        bus.ioctl_addr  = 25'd9;
        bus.ioctl_dout  = 8'h3C;
        next_cycle();
        reset              = 1'b0;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        check_eq("mrst_loaded", 32'(bus.rom_loaded), 32'd0);
        check_eq("mrst_core_reset", 32'(bus.core_reset), 32'd1);
        check_eq("mrst_we", 32'(bus.mem_we), 32'd0);
        check_eq("mrst_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("mrst_cpu_data", 32'(bus.cpu_data), 32'd0);
`ifdef ROM_CHECKSUM_EN
        check_eq("mrst_checksum", 32'(bus.checksum), 32'd0);
`endif
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            bus.ioctl_addr = 25'($urandom_range(0, 63));
            @(negedge clk_sys);
            check_eq("boot_we", 32'(bus.mem_we), 32'd0);
            next_cycle();
        end
        bus.ioctl_wr = 1'b0;
        start_download();
        send_byte(8'd0, 25'd3, 8'($urandom));
        finish_download();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ioctl_rom_arbiter.md
IOCTL_ROM_ARBITER -- requirements
Module: ioctl_rom_arbiter

Interface
REQ-001 SHALL provide parameter AW, default 16: ROM port address width.
REQ-002 SHALL provide parameter RST_HOLD, default 16: number of cycles core_reset stays high after a download completes or user_reset deasserts.
REQ-003 SHALL provide the following ports.
- clk_sys  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- user_reset  in  1  level request to hold the core in reset.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  download target.
- ioctl_wr  in  1  byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- cpu_req  in  1  CPU read request.
- cpu_addr  in  AW  CPU read address.
- cpu_ack  out  1  CPU read done.
- cpu_data  out  8  CPU read data.
- gfx_req  in  1  video read request.
- gfx_addr  in  AW  video read address.
- gfx_ack  out  1  video read done.
- gfx_data  out  8  video read data.
- mem_addr  out  AW  shared ROM port address.
- mem_we  out  1  shared ROM port write enable.
- mem_din  out  8  shared ROM port write data.
- mem_dout  in  8  shared ROM port read data; synchronous RAM, valid 1 cycle after address.
- core_reset  out  1  reset to game core.
- rom_loaded  out  1  at least one download has completed.
- checksum  out  8  byte sum of the download; present only with ROM_CHECKSUM_EN.

Function
REQ-004 FSM states SHALL be BOOT, LOAD, HOLD and RUN.
REQ-005 BOOT SHALL hold core_reset=1 and rom_loaded=0, and SHALL go to LOAD when ioctl_download=1.
REQ-006 In LOAD, when ioctl_wr=1, ioctl_index=0 and ioctl_addr<2^AW, the block SHALL drive mem_we=1, mem_addr=ioctl_addr[AW-1:0] and mem_din=ioctl_dout in the same cycle (combinational pass-through); all other bytes SHALL be ignored.
REQ-007 A falling edge of ioctl_download in LOAD SHALL set rom_loaded=1 (sticky until reset), load the hold counter with RST_HOLD, and go to HOLD.
REQ-008 HOLD SHALL keep core_reset=1 and decrement the counter each cycle while user_reset=0; it SHALL go to RUN on the cycle the counter reaches 0; user_reset=1 SHALL reload the counter.
REQ-009 In RUN, core_reset SHALL be 0.
- user_reset=1 in RUN SHALL go to HOLD with the counter reloaded.
- ioctl_download=1 in HOLD or RUN SHALL go to LOAD with core_reset=1 in the same cycle.
REQ-010 Reads SHALL be granted only in RUN, one in flight. Timing:
- grant cycle N: mem_addr = requester address, mem_we=0;
- cycle N+1: matching ack=1 for exactly one cycle, data = mem_dout registered and held until the next ack of that requester;
- no new grant in cycle N+1; peak throughput is one read per 2 cycles.
REQ-011 Arbitration SHALL be round-robin.
- Priority pointer resets to CPU.
- After each grant, the pointer points to the other requester.
- A single requester is granted regardless of the pointer.
REQ-012 A requester SHALL deassert req in its ack cycle; req still high in the cycle after ack SHALL be treated as a new request.
REQ-013 Entering LOAD with a read in flight SHALL abort it: no ack is issued, and mem_we SHALL never overlap a read grant.
REQ-014 When not granting or writing, mem_addr SHALL hold its last value and mem_we SHALL be 0.

Reset
REQ-015 reset SHALL force, on the next clock edge:
- state=BOOT; core_reset=1; rom_loaded=0;
- cpu_ack=gfx_ack=0; cpu_data=gfx_data=0; mem_we=0; mem_addr=0;
- hold counter=0; priority pointer=CPU; checksum=0.
reset SHALL override all other inputs, including a download in progress.

Configuration
REQ-016 With ROM_CHECKSUM_EN defined:
- checksum SHALL clear on the rising edge of ioctl_download;
- checksum SHALL add (mod 256) every accepted byte of REQ-006;
- checksum SHALL be stable from HOLD onward.
Without ROM_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Structure
REQ-017 A shared package SHALL hold the FSM state enum (BOOT, LOAD, HOLD, RUN), the ROM download index constant (0) and the requester-id typedef (CPU, GFX).
REQ-018 The hold counter SHALL be a sub-module reset_stretch (load, count, done); the arbiter, FSM and checksum stay in ioctl_rom_arbiter.

Verification
REQ-019 Power-up download: reset, then download 4 bytes 0x01,0x02,0x03,0x04 at addr 0..3, index 0.
- Expect mem_we pulses at addr 0..3 with matching data.
- Expect rom_loaded=1 on download fall.
- Expect core_reset to fall exactly RST_HOLD cycles later.
- With ROM_CHECKSUM_EN, expect checksum=0x0A.
REQ-020 Filtering: index 1 bytes and index 0 bytes at addr 0x10000 (AW=16) -> no mem_we.
REQ-021 Simultaneous reads: cpu_req and gfx_req high together, continuously re-requesting after each ack -> grants alternate CPU, GFX, CPU, GFX; each ack 1 cycle wide, 2 cycles apart; data equals preloaded contents.
REQ-022 Abort: download rises in the grant cycle of a CPU read -> no cpu_ack, core_reset=1 that cycle, state LOAD.
REQ-023 user_reset pulse of 3 cycles in RUN -> core_reset high for 3+RST_HOLD cycles; rom_loaded stays 1.
REQ-024 Mid-download reset: reset asserted during LOAD -> BOOT, rom_loaded=0, mem_we=0 next cycle, and no further writes until a new download starts.
